mul_pipeline: RTL
=================

MUL_PIPELINE -- requirements
Module: mul_pipeline

Interface
REQ-001 SHALL have parameter WORD_SIZE, default `WORD_SIZE (32), operand/result width.
REQ-002 SHALL have parameter MUL_STAGES, default 4, legal 2..8, number of pipeline register stages.
REQ-003 SHALL have parameter ROB_ID_SZ, default 7, ROB tag width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid  input  1  operation offered by the D/E register.
REQ-007 SHALL have port funct3  input  3  multiply variant.
REQ-008 SHALL have ports s1, s2  input  WORD_SIZE  rs1/rs2 operands.
REQ-009 SHALL have port rob_id  input  ROB_ID_SZ  tag carried with the operation.
REQ-010 SHALL have port stall  input  1  downstream (writeback arbiter) cannot take valid_out this cycle.
REQ-011 SHALL have port stall_out  output  1  combinational, upstream must hold its operation.
REQ-012 SHALL have ports result_out  output  WORD_SIZE, rob_id_out  output  ROB_ID_SZ, valid_out  output  1  (all registered).

Function
REQ-013 SHALL accept an operation on a posedge where valid=1 and stall_out=0; with valid=0 a bubble enters stage 0.
REQ-014 SHALL hold per-stage valid bit, rob_id, funct3 and partial data; valid_out/rob_id_out/result_out are the last stage's registers.
REQ-015 SHALL advance stage i when stage i+1 is empty or advancing; last stage advances when stall=0 or its valid=0 (bubble collapsing).
REQ-016 SHALL drive stall_out = stage0.valid & ~stage0.advance; never depends on valid.
REQ-017 SHALL produce valid_out=1 exactly MUL_STAGES posedges after acceptance when stall stays 0, giving one result per cycle throughput.
REQ-018 SHALL hold all last-stage outputs stable while valid_out=1 and stall=1.
REQ-019 SHALL preserve issue order; no operation is lost or duplicated under any stall pattern.
REQ-020 SHALL compute a 2*WORD_SIZE product: funct3 000 MUL low half; 001 MULH signed*signed high; 010 MULHSU signed s1*unsigned s2 high; 011 MULHU unsigned high; 1xx treated as 000.
REQ-021 SHALL split the product across stages freely but the result SHALL be bit-exact regardless of MUL_STAGES.
REQ-022 SHALL, on simultaneous accept and output retire, perform both in the same cycle.

Reset
REQ-023 SHALL on reset=1 at a posedge clear every stage valid bit, valid_out, rob_id_out and result_out to 0; reset overrides stall and valid.
REQ-024 SHALL not accept an operation on a reset cycle; in-flight operations are discarded (flush).
REQ-025 SHALL drive stall_out=0 in the cycle after reset.

Configuration
REQ-026 SHALL compile high-half support only when MUL_HIGH_EN is defined.
REQ-027 SHALL with MUL_HIGH_EN implement REQ-020 fully.
REQ-028 SHALL without MUL_HIGH_EN produce only the low WORD_SIZE bits of the product for every funct3 and instantiate no high-half logic.

Structure
REQ-029 SHALL take WORD_SIZE and funct3 encodings (MUL_F3_MUL/MULH/MULHSU/MULHU) from the shared package/defines header.
REQ-030 SHALL instantiate sub-module mul_stage (one valid/tag/data register slice with advance logic) MUL_STAGES times.

Verification
REQ-031 SHALL cover: reset, then MUL s1=7,s2=6,rob_id=3 -> valid_out=1, result_out=42, rob_id_out=3 exactly MUL_STAGES cycles later.
REQ-032 SHALL cover: MULH s1=0xFFFFFFFF, s2=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU s1=0xFFFFFFFF,s2=2 -> 0xFFFFFFFF (MUL_HIGH_EN defined); without it all three -> low half (0x00000001, 0x00000001, 0xFFFFFFFE).
REQ-033 SHALL cover: back-to-back issue of 10 ops, stall=1 for 3 cycles mid-stream -> stall_out asserts only once pipeline full, outputs held, all 10 results in order with correct tags.
REQ-034 SHALL cover: one op in flight, bubbles behind, stall=1 -> later ops accepted and compact behind it; stall_out=0 until all MUL_STAGES slots full.
REQ-035 SHALL cover: reset asserted with 3 ops in flight and stall=1 -> next cycle valid_out=0, stall_out=0, no flushed result ever appears.

Source files
------------

// File: rtl/mul_pipeline_pkg.sv
// Shared definitions for the multiply pipeline: default word size and funct3 encodings.
// High-half result support in the datapath is compiled in only when MUL_HIGH_EN is defined.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mul_pipeline_pkg;

    localparam int DEFAULT_WORD_SIZE = `WORD_SIZE;

    localparam logic [2:0] MUL_F3_MUL    = 3'b000;
    localparam logic [2:0] MUL_F3_MULH   = 3'b001;
    localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
    localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        SEL_LOW,
        SEL_HIGH_SS,
        SEL_HIGH_SU,
        SEL_HIGH_UU
    } mul_sel_e;

    // Encodings with funct3[2] set are not multiplies we know, so they fall back to MUL.
    function automatic mul_sel_e decode_f3(input logic [2:0] f3);
        mul_sel_e sel;
        case (f3)
            MUL_F3_MULH:   sel = SEL_HIGH_SS;
            MUL_F3_MULHSU: sel = SEL_HIGH_SU;
            MUL_F3_MULHU:  sel = SEL_HIGH_UU;
            default:       sel = SEL_LOW;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mul_stage.sv
// One pipeline slice: valid bit, tag and data register with elastic advance logic.
// A slice loads whenever it is empty or its contents move on to the next slice.
module mul_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_ready,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data,
    output logic              ready
);

    assign ready = ~valid | next_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (ready) begin
            valid <= in_valid;
            tag   <= in_tag;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/mul_pipeline.sv
// Elastic multiply pipeline of MUL_STAGES slices with in-order results and bubble collapsing.
// Define MUL_HIGH_EN to build MULH/MULHSU/MULHU; otherwise every funct3 yields the low product.
module mul_pipeline
    import mul_pipeline_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int MUL_STAGES = 4,
    parameter int ROB_ID_SZ  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] s1,
    input  logic [WORD_SIZE-1:0] s2,
    input  logic [ROB_ID_SZ-1:0] rob_id,
    input  logic                 stall,
    output logic                 stall_out,
    output logic [WORD_SIZE-1:0] result_out,
    output logic [ROB_ID_SZ-1:0] rob_id_out,
    output logic                 valid_out
);

    localparam int W = WORD_SIZE;
    localparam int LAST = MUL_STAGES - 1;

`ifdef MUL_HIGH_EN
    localparam int OP_W = 2 * W + 3;
`else
    localparam int OP_W = 2 * W;
`endif

    if (MUL_STAGES < 2 || MUL_STAGES > 8) begin : g_bad_stages
        $error("mul_pipeline: MUL_STAGES must be within 2..8");
    end

    logic [MUL_STAGES-1:0] stage_valid;
    logic [MUL_STAGES:0]   stage_ready;
    logic [ROB_ID_SZ-1:0]  stage_tag [MUL_STAGES];

    logic [OP_W-1:0] op_in;
    logic [OP_W-1:0] op_data;
    logic [W-1:0]    res_in   [1:LAST];
    logic [W-1:0]    res_data [1:LAST];

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] product;

    // The last slice drains when downstream takes it; readiness ripples back from here.
    assign stage_ready[MUL_STAGES] = ~stall;

    // Stage 0 is the only slice that can hold an offered op, so its readiness is the stall.
    assign stall_out = ~stage_ready[0];

`ifdef MUL_HIGH_EN
    logic [2:0]     op_f3;
    mul_sel_e       op_sel;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] full;

    assign op_in = {funct3, s1, s2};
    assign {op_f3, op_a, op_b} = op_data;

    // Sign-extending into 2W bits lets one unsigned multiplier serve every variant.
    always_comb begin
        op_sel = decode_f3(op_f3);
        ext_a  = {{W{1'b0}}, op_a};
        ext_b  = {{W{1'b0}}, op_b};
        case (op_sel)
            SEL_HIGH_SS: begin
                ext_a = {{W{op_a[W-1]}}, op_a};
                ext_b = {{W{op_b[W-1]}}, op_b};
            end
            SEL_HIGH_SU: ext_a = {{W{op_a[W-1]}}, op_a};
            default: ;
        endcase
        full    = ext_a * ext_b;
        product = (op_sel == SEL_LOW) ? full[W-1:0] : full[2*W-1:W];
    end
`else
    assign op_in = {s1, s2};
    assign {op_a, op_b} = op_data;

    always_comb begin
        product = op_a * op_b;
    end
`endif

    for (genvar i = 0; i < MUL_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            mul_stage #(
                .DATA_W (OP_W),
                .TAG_W  (ROB_ID_SZ)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .next_ready (stage_ready[1]),
                .in_valid   (valid),
                .in_tag     (rob_id),
                .in_data    (op_in),
                .valid      (stage_valid[0]),
                .tag        (stage_tag[0]),
                .data       (op_data),
                .ready      (stage_ready[0])
            );
        end else begin : g_rest
            if (i == 1) begin : g_product
                assign res_in[i] = product;
            end else begin : g_carry
                assign res_in[i] = res_data[i-1];
            end

            mul_stage #(
                .DATA_W (W),
                .TAG_W  (ROB_ID_SZ)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .next_ready (stage_ready[i+1]),
                .in_valid   (stage_valid[i-1]),
                .in_tag     (stage_tag[i-1]),
                .in_data    (res_in[i]),
                .valid      (stage_valid[i]),
                .tag        (stage_tag[i]),
                .data       (res_data[i]),
                .ready      (stage_ready[i])
            );
        end
    end

    assign valid_out  = stage_valid[LAST];
    assign rob_id_out = stage_tag[LAST];
    assign result_out = res_data[LAST];

endmodule
